// File: rtl/debounce_ab.sv
// rtl/debounce_ab.sv - dual-channel push-button debouncer; rise pulses optional via DEBOUNCE_EDGE_EN
// Each channel: two-flop synchronizer feeding a STABLE/PENDING counter FSM.

module debounce_ab_chan #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic in_raw,
`ifdef DEBOUNCE_EDGE_EN
   output logic out_rise,
`endif
   output logic out_level
);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   // A one-cycle debounce commits straight from STABLE without visiting PENDING.
   localparam logic SINGLE = (DB_CYCLES == 1);

   state_e           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             out_q,   out_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             mismatch;
   logic             cnt_done;

   assign mismatch = (sync2_q != out_q);
   assign cnt_done = (cnt_q == CNT_W'(DB_CYCLES - 1));

   always_comb begin
      sync1_d = in_raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_STABLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         out_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STABLE: begin
            if (mismatch && !SINGLE) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (!mismatch || cnt_done) begin
               state_d = ST_STABLE;
            end
         end
         default: state_d = ST_STABLE;
      endcase
   end

   always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      case (state_q)
         ST_STABLE: begin
            if (mismatch) begin
               if (SINGLE) begin
                  out_d = sync2_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = CNT_W'(1);
               end
            end
         end
         ST_PENDING: begin
            if (!mismatch) begin
               cnt_d = '0;
            end else if (cnt_done) begin
               out_d = sync2_q;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign out_level = out_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, rise_d;

   // Registered alongside the level so the pulse occupies the first cycle of the new high.
   always_comb begin
      rise_d = out_d & ~out_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rise_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
      end
   end

   assign out_rise = rise_q;
`endif

endmodule

module debounce_ab #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_a,
   input  logic btn_b,
`ifdef DEBOUNCE_EDGE_EN
   output logic A_rise,
   output logic B_rise,
`endif
   output logic A,
   output logic B
);

   debounce_ab_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_chan_a (
      .clk       (clk),
      .rst       (rst),
      .in_raw    (btn_a),
`ifdef DEBOUNCE_EDGE_EN
      .out_rise  (A_rise),
`endif
      .out_level (A)
   );

   debounce_ab_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_chan_b (
      .clk       (clk),
      .rst       (rst),
      .in_raw    (btn_b),
`ifdef DEBOUNCE_EDGE_EN
      .out_rise  (B_rise),
`endif
      .out_level (B)
   );

endmodule

// File: tb/tb_debounce_ab.sv
// tb/tb_debounce_ab.sv - directed bench for debounce_ab with a sliding-window reference model
// Rise-pulse checks are compiled in when DEBOUNCE_EDGE_EN is defined.

module tb_debounce_ab;

   localparam int DB    = 4;
   localparam int LOG_N = 1024;

   logic clk = 1'b0;
   logic rst;
   logic btn_a;
   logic btn_b;
   logic A;
   logic B;
`ifdef DEBOUNCE_EDGE_EN
   logic A_rise;
   logic B_rise;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   debounce_ab #(
      .DB_CYCLES (DB),
      .CNT_W     (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_a  (btn_a),
      .btn_b  (btn_b),
`ifdef DEBOUNCE_EDGE_EN
      .A_rise (A_rise),
      .B_rise (B_rise),
`endif
      .A      (A),
      .B      (B)
   );

   always #2 clk = ~clk;

   // Model: the debouncer sees each raw sample two edges late; the level flips once
   // the last DB seen values all disagree with it.
   bit       raw_log  [2][LOG_N];
   bit       seen_log [2][LOG_N];
   int       since_rst = 0;
   bit [1:0] m_out  = '0;
   bit [1:0] m_rise = '0;

   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         since_rst = 0;
         m_out     = '0;
         m_rise    = '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            raw_log[c][since_rst]  = (c == 0) ? btn_a : btn_b;
            seen_log[c][since_rst] = (since_rst >= 2) ? raw_log[c][since_rst-2] : 1'b0;
            m_rise[c] = 1'b0;
            if (since_rst + 1 >= DB) begin
               int run;
               run = 0;
               for (int k = 0; k < DB; k++) begin
                  if (seen_log[c][since_rst-k] != m_out[c]) run++;
               end
               if (run == DB) begin
                  m_out[c]  = ~m_out[c];
                  m_rise[c] = m_out[c];
               end
            end
         end
         if (since_rst < LOG_N - 1) since_rst++;
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_A", A, m_out[0]);
         check("model_B", B, m_out[1]);
`ifdef DEBOUNCE_EDGE_EN
         check("model_A_rise", A_rise, m_rise[0]);
         check("model_B_rise", B_rise, m_rise[1]);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst   = 1'b0;
      btn_a = 1'b0;
      btn_b = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_A", A, 1'b0);
      check("reset_B", B, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
      check("reset_A_rise", A_rise, 1'b0);
      check("reset_B_rise", B_rise, 1'b0);
`endif

      // press A from edge 1: visible at edge 6
      rst   = 1'b1;
      btn_a = 1'b1;
      ticks(5);
      check("press_A_e5", A, 1'b0);
      tick();
      check("press_A_e6", A, 1'b1);
      check("press_B_idle", B, 1'b0);

      // release A: falls at edge 6, no rise pulse
      btn_a = 1'b0;
      ticks(5);
      check("release_A_e5", A, 1'b1);
      tick();
      check("release_A_e6", A, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
      check("release_A_norise", A_rise, 1'b0);
`endif

      // short pulses of 2 and DB-1 raw cycles are rejected
      btn_a = 1'b1;
      ticks(2);
      btn_a = 1'b0;
      ticks(8);
      check("glitch2_A", A, 1'b0);
      btn_a = 1'b1;
      ticks(3);
      btn_a = 1'b0;
      ticks(8);
      check("glitch3_A", A, 1'b0);

      // a pulse of exactly DB raw cycles is accepted, then debounced back low
      btn_a = 1'b1;
      ticks(4);
      btn_a = 1'b0;
      ticks(2);
      check("pulse4_A_e6", A, 1'b1);
      ticks(3);
      check("pulse4_A_e9", A, 1'b1);
      tick();
      check("pulse4_A_e10", A, 1'b0);

      // simultaneous press on both channels
      btn_a = 1'b1;
      btn_b = 1'b1;
      ticks(5);
      check("both_A_e5", A, 1'b0);
      check("both_B_e5", B, 1'b0);
      tick();
      check("both_A_e6", A, 1'b1);
      check("both_B_e6", B, 1'b1);
`ifdef DEBOUNCE_EDGE_EN
      check("both_A_rise_e6", A_rise, 1'b1);
      check("both_B_rise_e6", B_rise, 1'b1);
      tick();
      check("both_A_rise_e7", A_rise, 1'b0);
      check("both_B_rise_e7", B_rise, 1'b0);
`else
      tick();
`endif
      btn_a = 1'b0;
      btn_b = 1'b0;
      ticks(6);
      check("both_A_low", A, 1'b0);
      check("both_B_low", B, 1'b0);

      // two separate presses on B, each with a single rise pulse
      for (int p = 0; p < 2; p++) begin
         btn_b = 1'b1;
         ticks(6);
         check("press_B_level", B, 1'b1);
`ifdef DEBOUNCE_EDGE_EN
         check("press_B_rise_on", B_rise, 1'b1);
         tick();
         check("press_B_rise_off", B_rise, 1'b0);
`else
         tick();
`endif
         btn_b = 1'b0;
         ticks(6);
         check("release_B_level", B, 1'b0);
      end

      // reset mid-PENDING discards progress; full latency restarts after release
      btn_a = 1'b1;
      btn_b = 1'b1;
      ticks(3);
      rst = 1'b0;
      tick();
      check("midrst_A_e4", A, 1'b0);
      check("midrst_B_e4", B, 1'b0);
      rst = 1'b1;
      ticks(5);
      check("midrst_A_e9", A, 1'b0);
      tick();
      check("midrst_A_e10", A, 1'b1);
      check("midrst_B_e10", B, 1'b1);

      ticks(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/debounce_ab.md
DEBOUNCE_AB -- requirements
Module: debounce_ab

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized cycles required before an output level changes; legal range 1..2^CNT_W.
REQ-002 Parameter CNT_W, default 3: width of each channel's stability counter.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-low.
REQ-005 Port btn_a  input  1: raw asynchronous push-button, channel A.
REQ-006 Port btn_b  input  1: raw asynchronous push-button, channel B.
REQ-007 Port A  output  1: debounced registered level, channel A; drives FSM input A.
REQ-008 Port B  output  1: debounced registered level, channel B; drives FSM input B.
REQ-009 Port A_rise  output  1: one-cycle pulse on a debounced rising edge of A; present only with DEBOUNCE_EDGE_EN.
REQ-010 Port B_rise  output  1: one-cycle pulse on a debounced rising edge of B; present only with DEBOUNCE_EDGE_EN.

Function
REQ-011 Each channel SHALL pass its raw input through a two-flop synchronizer; the second flop output is the synchronized value s.
REQ-012 Each channel SHALL implement a two-state FSM: STABLE (s equals output) and PENDING (s differs from output, counter running).
REQ-013 In STABLE, when s != output: go to PENDING, counter = 1; with DB_CYCLES=1, update the output on that edge and remain in STABLE instead.
REQ-014 In PENDING, when s != output and counter == DB_CYCLES-1: output <= s, counter <= 0, go to STABLE.
REQ-015 In PENDING, when s != output and counter < DB_CYCLES-1: counter increments.
REQ-016 In PENDING, when s == output on any edge (glitch): counter <= 0, go to STABLE, output unchanged.
REQ-017 Latency: a raw level held stable from its first sampling edge (edge 1) SHALL appear on the output at edge DB_CYCLES+2; for DB_CYCLES=4, edge 6.
REQ-018 A raw pulse that is stable for fewer than DB_CYCLES synchronized cycles SHALL NOT change the output.
REQ-019 Channels A and B SHALL be fully independent; simultaneous transitions on both SHALL yield simultaneous output changes with identical latency.
REQ-020 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-021 Outputs A and B SHALL be registered directly, with no combinational path from btn_a or btn_b.

Reset
REQ-022 When rst=0 on a rising edge, synchronizer flops, A, B, counters, and A_rise/B_rise SHALL be cleared to 0, and both FSMs SHALL enter STABLE.
REQ-023 Reset asserted mid-PENDING SHALL discard the pending transition; after release, debouncing restarts with the full latency.
REQ-024 Reset SHALL have no effect between clock edges.

Configuration
REQ-025 Macro DEBOUNCE_EDGE_EN defined: A_rise/B_rise exist and equal 1 for exactly the cycle following the edge on which the corresponding output goes 0->1; 1->0 transitions produce no pulse.
REQ-026 Macro DEBOUNCE_EDGE_EN undefined: A_rise/B_rise ports and their logic are absent; A/B behaviour is identical.

Verification
REQ-027 Clock period 4; rst=0 for one edge, then 1; btn_a=1 held from edge 1 -> A=1 at edge 6; B stays 0.
REQ-028 With A=0, btn_a high for 2 cycles then low -> A never changes; FSM returns to STABLE with counter 0.
REQ-029 btn_a and btn_b both rise on the same edge and are held -> A and B go to 1 on the same edge (edge 6).
REQ-030 With A=1, btn_a released and held low -> A=0 at edge 6; with DEBOUNCE_EDGE_EN, A_rise stays 0 throughout.
REQ-031 btn_a=1 held; rst=0 asserted at edge 4 (PENDING) then released -> A=0 through reset; A=1 six edges after release.
REQ-032 With DEBOUNCE_EDGE_EN, a debounced 0->1 on B -> B_rise=1 for exactly one cycle; a second press after release produces a second single pulse.
